// File: rtl/mmul.sv
// Sequential 3x3 matrix multiplier, 8-bit unsigned elements, C = A x B mod 256.
// One multiply-accumulate per clock; the product is published in a single update.
module mmul (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [71:0] mat_a,
  input  logic [71:0] mat_b,
  output logic [71:0] mat_a_plus_b,
  output logic        done
);

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 72;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [MW-1:0] op_a;
  logic [MW-1:0] op_b;
  logic [MW-1:0] result;
  logic [AW-1:0] acc;
  logic [1:0]    ci, cj, ck;
  logic          fin;

  logic [3:0]    a_idx, b_idx, c_idx;
  logic [EW-1:0] a_el, b_el;
  logic [PW-1:0] prod;
  logic [AW-1:0] acc_next;

  // Element selection and MAC for the current (i, j, k)
  assign a_idx    = 4'(ci) * 4'd3 + 4'(ck);
  assign b_idx    = 4'(ck) * 4'd3 + 4'(cj);
  assign c_idx    = 4'(ci) * 4'd3 + 4'(cj);
  assign a_el     = op_a[{a_idx, 3'b000} +: EW];
  assign b_el     = op_b[{b_idx, 3'b000} +: EW];
  assign prod     = PW'(a_el) * PW'(b_el);
  assign acc_next = acc + AW'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable) state_next = ST_COMPUTE;
      ST_COMPUTE: if (fin)    state_next = ST_DONE;
      ST_DONE:    if (!enable) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // fin marks that the last element has landed in result; the next edge publishes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      acc          <= '0;
      ci           <= '0;
      cj           <= '0;
      ck           <= '0;
      fin          <= 1'b0;
      mat_a_plus_b <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (enable) begin
            op_a <= mat_a;
            op_b <= mat_b;
            acc  <= '0;
            ci   <= '0;
            cj   <= '0;
            ck   <= '0;
            fin  <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          if (fin) begin
            mat_a_plus_b <= result;
            done         <= 1'b1;
            fin          <= 1'b0;
          end else if (ck == 2'd2) begin
            result[{c_idx, 3'b000} +: EW] <= acc_next[EW-1:0];
            acc <= '0;
            ck  <= '0;
            if (cj == 2'd2) begin
              cj <= '0;
              if (ci == 2'd2) begin
                ci  <= '0;
                fin <= 1'b1;
              end else begin
                ci <= ci + 2'd1;
              end
            end else begin
              cj <= cj + 2'd1;
            end
          end else begin
            acc <= acc_next;
            ck  <= ck + 2'd1;
          end
        end
        ST_DONE: begin
          if (!enable) done <= 1'b0;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul.sv
// Directed self-checking bench for mmul: nominal, wrap, identity, handshake, mid-op reset.
module tb_mmul;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [71:0] mat_a;
  logic [71:0] mat_b;
  logic [71:0] mat_a_plus_b;
  logic        done;

  int n_tests;
  int n_fail;
  int lat;

  logic [71:0] a_nom, b_nom, c_nom;
  logic [71:0] a_ff, c_ff;
  logic [71:0] a_id, b_id;

  mmul dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .mat_a_plus_b (mat_a_plus_b),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an operation and count edges until done; optional mid-run enable drop / mat_a change
  task automatic run_op(input logic [71:0] a, input logic [71:0] b,
                        input int drop_en_at, input int chg_a_at, output int latency);
    logic [71:0] prev_out;
    logic        stable;
    @(negedge clk);
    mat_a  = a;
    mat_b  = b;
    enable = 1'b1;
    prev_out = mat_a_plus_b;
    stable   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    latency = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == drop_en_at) enable = 1'b0;
      if (n == chg_a_at) mat_a = ~a;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        latency = n;
        break;
      end
      if (mat_a_plus_b !== prev_out) stable = 1'b0;
    end
    chk("out_stable_during_compute", 72'(stable), 72'(1));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    a_nom = {8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd5, 8'd3, 8'd8, 8'd2};
    b_nom = {8'd0, 8'd0, 8'd3, 8'd5, 8'd6, 8'd1, 8'd2, 8'd0, 8'd8};
    c_nom = {8'd16, 8'd12, 8'd29, 8'd10, 8'd0, 8'd43, 8'd44, 8'd48, 8'd33};
    a_ff  = {9{8'hFF}};
    c_ff  = {9{8'd3}};
    a_id  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b_id  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    reset  = 1'b0;
    enable = 1'b0;
    mat_a  = '0;
    mat_b  = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 72'(done), 72'(0));
    chk("reset_out", mat_a_plus_b, 72'(0));
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_done", 72'(done), 72'(0));
    chk("idle_out", mat_a_plus_b, 72'(0));

    // Nominal product, then hold enable in DONE
    run_op(a_nom, b_nom, 0, 0, lat);
    chk("nom_latency", 72'(lat), 72'(28));
    chk("nom_result", mat_a_plus_b, c_nom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_hold", 72'(done), 72'(1));
    chk("done_hold_out", mat_a_plus_b, c_nom);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_drop", 72'(done), 72'(0));
    chk("done_drop_out", mat_a_plus_b, c_nom);

    // Overflow wrap
    run_op(a_ff, a_ff, 0, 0, lat);
    chk("wrap_latency", 72'(lat), 72'(28));
    chk("wrap_result", mat_a_plus_b, c_ff);
    enable = 1'b0;
    @(posedge clk);

    // Identity, enable dropped and mat_a disturbed mid-compute
    run_op(a_id, b_id, 5, 12, lat);
    chk("ident_latency", 72'(lat), 72'(28));
    chk("ident_result", mat_a_plus_b, b_id);
    @(posedge clk);
    @(negedge clk);
    chk("ident_done_clear", 72'(done), 72'(0));
    chk("ident_out_kept", mat_a_plus_b, b_id);

    // Re-raise enable for a fresh operation
    run_op(a_nom, b_nom, 0, 0, lat);
    chk("rerun_latency", 72'(lat), 72'(28));
    chk("rerun_result", mat_a_plus_b, c_nom);
    enable = 1'b0;
    @(posedge clk);

    // Reset at COMPUTE cycle 10
    @(negedge clk);
    mat_a  = a_ff;
    mat_b  = a_ff;
    enable = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_done", 72'(done), 72'(0));
    chk("midrst_out", mat_a_plus_b, 72'(0));
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_op(a_id, b_id, 0, 0, lat);
    chk("postrst_latency", 72'(lat), 72'(28));
    chk("postrst_result", mat_a_plus_b, b_id);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_idle", 72'(done), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmul.md
Name: mmul

Overview:
- Sequential 3x3 matrix multiplier over 8-bit unsigned elements: computes C = A x B modulo 256.
- Processes one multiply-accumulate per clock.
- Standalone compute block: the host loads two packed 72-bit matrices, raises enable, waits for done, then reads the packed 72-bit product.
- The output port is named mat_a_plus_b for system compatibility; its content is the matrix product.

Parameters:
- None. Dimension is fixed at 3x3; element width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable  input  1  start request and hold; sampled in IDLE and DONE only.
- mat_a  input  72  matrix A; element [i][j] at bits (i*3+j)*8 +: 8.
- mat_b  input  72  matrix B; same packing as mat_a.
- mat_a_plus_b  output  72  registered product C; same packing.
- done  output  1  registered; high while a valid result is presented in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mat_a_plus_b=0; done=0; operand, accumulator and result registers cleared; i/j/k counters=0.
- States: IDLE, COMPUTE, DONE.
- IDLE, enable=1 at an edge:
  - capture mat_a and mat_b into internal operand registers;
  - clear i, j, k and the accumulator;
  - go to COMPUTE.
- IDLE, enable=0: stay in IDLE; done=0.
- COMPUTE, each cycle:
  - acc_next = acc + a[i][k]*b[k][j], using 16-bit products and an accumulator of at least 18 bits.
  - k runs 0..2. When k=2, write acc_next[7:0] into result element [i][j], clear acc, set k=0, and advance j (then i) in row-major order.
  - 27 COMPUTE cycles in total.
- After the cycle with i=j=k=2:
  - copy the full result register to mat_a_plus_b;
  - assert done;
  - go to DONE.
  - mat_a_plus_b therefore changes only in a single update per operation.
- Latency: done rises on the 28th rising edge after the edge that sampled enable=1 in IDLE.
- Enable and inputs during COMPUTE:
  - enable is ignored; deassertion does not abort the operation.
  - Changes on mat_a/mat_b are ignored because operands are latched.
- DONE:
  - done=1 and mat_a_plus_b stable while enable=1.
  - When enable=0 is sampled: done=0, go to IDLE. mat_a_plus_b retains the last result.
- A new operation requires enable to be low for at least one edge after DONE; no back-to-back restart from DONE.
- Arithmetic: unsigned; each output element = (sum over k of a[i][k]*b[k][j]) mod 256. No saturation, no overflow flag.
- Reset mid-operation: immediate abort to IDLE with the reset values above. The partial result is discarded.

Test Plan:
- Reset: hold reset=0 for 10 cycles -> done=0, mat_a_plus_b=0; release reset with enable=0 -> remains IDLE, outputs unchanged.
- Nominal product:
  - Stimulus: mat_a={8'd1,8'd2,8'd3,8'd1,8'd0,8'd5,8'd3,8'd8,8'd2}, mat_b={8'd0,8'd0,8'd3,8'd5,8'd6,8'd1,8'd2,8'd0,8'd8} (first listed = MSB = element [2][2]), enable=1.
  - Required: done rises 28 edges after the sampling edge. Elements [0][0..2]=33,48,44; [1][0..2]=43,0,10; [2][0..2]=29,12,16.
- Overflow wrap: all A and B elements 255 -> every output element = 3 (195075 mod 256).
- Identity: A=identity (diag 1, else 0), B elements [i][j]=i*3+j+1 -> output equals B.
- Handshake:
  - Drop enable during COMPUTE -> the operation still completes and done asserts at the same cycle.
  - Change mat_a during COMPUTE -> result unaffected.
  - Drop enable in DONE -> done=0 next edge; output retained; re-raise enable -> new result after 28 edges.
- Reset mid-operation: assert reset=0 at COMPUTE cycle 10 -> done=0 and mat_a_plus_b=0 immediately; after release with enable=1 a full fresh 28-cycle operation gives the correct product.
